// File: rtl/synth_voice_pkg.sv
// Shared constants, FSM state type and rank-width helper for the voice allocator.
package synth_voice_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        RELEASE
    } state_t;

    function automatic int rank_w(input int voices);
        return (voices > 2) ? $clog2(voices) : 1;
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Per-voice recency ranks (0 = most recent). A touch moves the voice to the
// front and ages every voice that was more recent than it.
module voice_lru
    import synth_voice_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int RW     = rank_w(VOICES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      touch,
    input  logic [RW-1:0]             touch_idx,
    output logic [VOICES-1:0][RW-1:0] rank
);

    logic [RW-1:0] touch_rank;

    assign touch_rank = rank[touch_idx];

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_slot
            logic [RW-1:0] rank_q;
            logic [RW-1:0] rank_d;

            always_comb begin
                rank_d = rank_q;
                if (touch) begin
                    if (touch_idx == RW'(gi)) begin
                        rank_d = '0;
                    end else if (rank_q < touch_rank) begin
                        rank_d = rank_q + 1'b1;
                    end
                end
            end

            // Voice 0 starts as the oldest so the first notes fill slots in order.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rank_q <= RW'(VOICES - 1 - gi);
                end else begin
                    rank_q <= rank_d;
                end
            end

            assign rank[gi] = rank_q;
        end
    endgenerate

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: retrigger, LRU free voice, or oldest-voice steal.
// Define VOICE_ALLOC_SUSTAIN_EN to enable sustain-pedal hold/release handling.
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int NOTE_W = synth_voice_pkg::NOTE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NOTE_W-1:0]            ev_vel,
    input  logic                         sustain,
    output logic [VOICES-1:0]            voice_gate,
    output logic [VOICES*NOTE_W-1:0]     voice_note,
    output logic [VOICES*NOTE_W-1:0]     voice_vel,
    output logic [VOICES-1:0]            voice_retrig,
    output logic                         stolen,
    output logic [$clog2(VOICES+1)-1:0]  active_cnt
);

    localparam int IW = rank_w(VOICES);
    localparam int CW = $clog2(VOICES + 1);

    state_t                        state_q, state_d;
    logic [IW-1:0]                 scan_k_q, scan_k_d;
    logic                          ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]             ev_note_q, ev_note_d;
    logic [NOTE_W-1:0]             ev_vel_q, ev_vel_d;
    logic                          match_ok_q, match_ok_d;
    logic                          free_ok_q, free_ok_d;
    logic [IW-1:0]                 match_idx_q, match_idx_d;
    logic [IW-1:0]                 free_idx_q, free_idx_d;
    logic [IW-1:0]                 free_rank_q, free_rank_d;
    logic [IW-1:0]                 old_idx_q, old_idx_d;
    logic [IW-1:0]                 old_rank_q, old_rank_d;
    logic [VOICES-1:0]             gate_q, gate_d;
    logic [VOICES-1:0]             held_q, held_d;
    logic [VOICES-1:0]             retrig_q, retrig_d;
    logic [VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [VOICES-1:0][NOTE_W-1:0] vel_q, vel_d;
    logic                          stolen_q, stolen_d;
    logic [CW-1:0]                 active_cnt_q, active_cnt_d;
    logic                          touch;
    logic [IW-1:0]                 touch_idx;
    logic [IW-1:0]                 target;
    logic [VOICES-1:0][IW-1:0]     rank;
    logic                          rel_req;

    voice_lru #(
        .VOICES (VOICES),
        .RW     (IW)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (touch),
        .touch_idx (touch_idx),
        .rank      (rank)
    );

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic sus_q;
    logic rel_pend_q, rel_pend_d;

    // A pedal release seen while busy is remembered until the FSM is idle again.
    assign rel_req = rel_pend_q | (sus_q & ~sustain);

    always_comb begin
        rel_pend_d = rel_pend_q;
        if (state_q == IDLE) begin
            rel_pend_d = 1'b0;
        end else if (sus_q & ~sustain) begin
            rel_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sus_q      <= 1'b0;
            rel_pend_q <= 1'b0;
        end else begin
            sus_q      <= sustain;
            rel_pend_q <= rel_pend_d;
        end
    end
`else
    logic unused_sustain;
    assign unused_sustain = sustain;
    assign rel_req        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        scan_k_d     = scan_k_q;
        ev_on_d      = ev_on_q;
        ev_note_d    = ev_note_q;
        ev_vel_d     = ev_vel_q;
        match_ok_d   = match_ok_q;
        free_ok_d    = free_ok_q;
        match_idx_d  = match_idx_q;
        free_idx_d   = free_idx_q;
        free_rank_d  = free_rank_q;
        old_idx_d    = old_idx_q;
        old_rank_d   = old_rank_q;
        gate_d       = gate_q;
        held_d       = held_q;
        note_d       = note_q;
        vel_d        = vel_q;
        retrig_d     = '0;
        stolen_d     = 1'b0;
        touch        = 1'b0;
        touch_idx    = '0;
        target       = old_idx_q;
        active_cnt_d = '0;

        case (state_q)
            IDLE: begin
                if (rel_req) begin
                    state_d = RELEASE;
                end else if (ev_valid) begin
                    state_d    = SCAN;
                    scan_k_d   = '0;
                    ev_on_d    = ev_on & (ev_vel != '0);
                    ev_note_d  = ev_note;
                    ev_vel_d   = ev_vel;
                    match_ok_d = 1'b0;
                    free_ok_d  = 1'b0;
                end
            end
            SCAN: begin
                if (!match_ok_q && gate_q[scan_k_q] && !held_q[scan_k_q] &&
                    note_q[scan_k_q] == ev_note_q) begin
                    match_ok_d  = 1'b1;
                    match_idx_d = scan_k_q;
                end
                if (!gate_q[scan_k_q] && (!free_ok_q || rank[scan_k_q] > free_rank_q)) begin
                    free_ok_d   = 1'b1;
                    free_idx_d  = scan_k_q;
                    free_rank_d = rank[scan_k_q];
                end
                if (scan_k_q == '0 || rank[scan_k_q] > old_rank_q) begin
                    old_idx_d  = scan_k_q;
                    old_rank_d = rank[scan_k_q];
                end
                scan_k_d = scan_k_q + 1'b1;
                if (scan_k_q == IW'(VOICES - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    if (match_ok_q) begin
                        target = match_idx_q;
                    end else if (free_ok_q) begin
                        target = free_idx_q;
                    end else begin
                        target   = old_idx_q;
                        stolen_d = gate_q[old_idx_q];
                    end
                    gate_d[target]   = 1'b1;
                    held_d[target]   = 1'b0;
                    note_d[target]   = ev_note_q;
                    vel_d[target]    = ev_vel_q;
                    retrig_d[target] = 1'b1;
                    touch            = 1'b1;
                    touch_idx        = target;
                end else if (match_ok_q) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    if (sustain) begin
                        held_d[match_idx_q] = 1'b1;
                    end else begin
                        gate_d[match_idx_q] = 1'b0;
                    end
`else
                    gate_d[match_idx_q] = 1'b0;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gate_d  = gate_q & ~held_q;
                held_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < VOICES; i++) begin
            active_cnt_d = active_cnt_d + CW'(gate_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            scan_k_q     <= '0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            ev_vel_q     <= '0;
            match_ok_q   <= 1'b0;
            free_ok_q    <= 1'b0;
            match_idx_q  <= '0;
            free_idx_q   <= '0;
            free_rank_q  <= '0;
            old_idx_q    <= '0;
            old_rank_q   <= '0;
            gate_q       <= '0;
            held_q       <= '0;
            note_q       <= '0;
            vel_q        <= '0;
            retrig_q     <= '0;
            stolen_q     <= 1'b0;
            active_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            scan_k_q     <= scan_k_d;
            ev_on_q      <= ev_on_d;
            ev_note_q    <= ev_note_d;
            ev_vel_q     <= ev_vel_d;
            match_ok_q   <= match_ok_d;
            free_ok_q    <= free_ok_d;
            match_idx_q  <= match_idx_d;
            free_idx_q   <= free_idx_d;
            free_rank_q  <= free_rank_d;
            old_idx_q    <= old_idx_d;
            old_rank_q   <= old_rank_d;
            gate_q       <= gate_d;
            held_q       <= held_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            retrig_q     <= retrig_d;
            stolen_q     <= stolen_d;
            active_cnt_q <= active_cnt_d;
        end
    end

    assign ev_ready     = (state_q == IDLE) & ~rel_req;
    assign voice_gate   = gate_q;
    assign voice_note   = note_q;
    assign voice_vel    = vel_q;
    assign voice_retrig = retrig_q;
    assign stolen       = stolen_q;
    assign active_cnt   = active_cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a queue-based LRU reference model
// checked every cycle, plus hand-computed spot checks.
module tb_voice_allocator;

    localparam int VOICES = 8;
    localparam int NOTE_W = 7;
    localparam int CW     = $clog2(VOICES + 1);
`ifdef VOICE_ALLOC_SUSTAIN_EN
    localparam bit SUS_EN = 1'b1;
`else
    localparam bit SUS_EN = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        ev_valid;
    logic                        ev_ready;
    logic                        ev_on;
    logic [NOTE_W-1:0]           ev_note;
    logic [NOTE_W-1:0]           ev_vel;
    logic                        sustain;
    logic [VOICES-1:0]           voice_gate;
    logic [VOICES*NOTE_W-1:0]    voice_note;
    logic [VOICES*NOTE_W-1:0]    voice_vel;
    logic [VOICES-1:0]           voice_retrig;
    logic                        stolen;
    logic [CW-1:0]               active_cnt;

    voice_allocator #(
        .VOICES (VOICES),
        .NOTE_W (NOTE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .sustain      (sustain),
        .voice_gate   (voice_gate),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .voice_retrig (voice_retrig),
        .stolen       (stolen),
        .active_cnt   (active_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: lru queue front = most recently assigned voice.
    bit              m_gate [VOICES];
    bit              m_held [VOICES];
    bit [NOTE_W-1:0] m_note [VOICES];
    bit [NOTE_W-1:0] m_vel  [VOICES];
    int              lru[$];
    bit [VOICES-1:0] exp_retrig;
    bit              exp_stolen;
    bit              exp_ready;
    bit              chk_en = 1'b0;
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        lru.delete();
        for (int i = VOICES - 1; i >= 0; i--) lru.push_back(i);
        for (int i = 0; i < VOICES; i++) begin
            m_gate[i] = 1'b0;
            m_held[i] = 1'b0;
            m_note[i] = '0;
            m_vel[i]  = '0;
        end
        exp_retrig = '0;
        exp_stolen = 1'b0;
        exp_ready  = 1'b1;
    endfunction

    function automatic void commit(input bit on, input bit [NOTE_W-1:0] n, input bit [NOTE_W-1:0] v);
        int m = -1;
        int t = -1;
        for (int i = 0; i < VOICES; i++)
            if (m < 0 && m_gate[i] && !m_held[i] && m_note[i] == n) m = i;
        if (on && v != 0) begin
            if (m >= 0) t = m;
            else begin
                for (int p = lru.size() - 1; p >= 0; p--)
                    if (t < 0 && !m_gate[lru[p]]) t = lru[p];
                if (t < 0) begin
                    t = lru[lru.size() - 1];
                    exp_stolen = m_gate[t];
                end
            end
            m_gate[t] = 1'b1;
            m_held[t] = 1'b0;
            m_note[t] = n;
            m_vel[t]  = v;
            exp_retrig[t] = 1'b1;
            for (int p = 0; p < lru.size(); p++)
                if (lru[p] == t) begin
                    lru.delete(p);
                    break;
                end
            lru.push_front(t);
        end else if (m >= 0) begin
            if (SUS_EN && sustain) m_held[m] = 1'b1;
            else m_gate[m] = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        logic [VOICES-1:0]        g;
        logic [VOICES*NOTE_W-1:0] en;
        logic [VOICES*NOTE_W-1:0] ev;
        int                       cnt;
        if (chk_en) begin
            cnt = 0;
            for (int i = 0; i < VOICES; i++) begin
                g[i] = m_gate[i];
                en[i*NOTE_W +: NOTE_W] = m_note[i];
                ev[i*NOTE_W +: NOTE_W] = m_vel[i];
                cnt += int'(m_gate[i]);
            end
            check("ev_ready", 64'(ev_ready), 64'(exp_ready));
            check("voice_gate", 64'(voice_gate), 64'(g));
            check("voice_note", 64'(voice_note), 64'(en));
            check("voice_vel", 64'(voice_vel), 64'(ev));
            check("voice_retrig", 64'(voice_retrig), 64'(exp_retrig));
            check("stolen", 64'(stolen), 64'(exp_stolen));
            check("active_cnt", 64'(active_cnt), 64'(cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_retrig = '0;
        exp_stolen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    // mode 0: plain event; 1: extra ev_valid pulse mid-scan; 2: rst mid-scan
    task automatic send(input bit on, input bit [NOTE_W-1:0] note, input bit [NOTE_W-1:0] vel,
                        input int mode);
        step();
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        ev_vel   = vel;
        @(posedge clk);
        #1;
        ev_valid  = 1'b0;
        exp_ready = 1'b0;
        for (int c = 1; c <= VOICES + 1; c++) begin
            if (mode == 1) begin
                ev_valid = (c == 3);
                ev_on    = 1'b1;
                ev_note  = note + 7'd1;
                ev_vel   = 7'd33;
            end
            if (mode == 2 && c == 3) rst = 1'b1;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                model_reset();
                return;
            end
        end
        ev_valid = 1'b0;
        commit(on, note, vel);
        exp_ready = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
        sustain  = 1'b0;

        do_reset();
        check("rst_ready", 64'(ev_ready), 64'd1);
        check("rst_gate", 64'(voice_gate), 64'd0);
        check("rst_active", 64'(active_cnt), 64'd0);

        // First note lands on voice 0, exactly VOICES+1 edges after accept.
        send(1'b1, 7'd60, 7'd100, 0);
        check("first_gate", 64'(voice_gate), 64'h01);
        check("first_note", 64'(voice_note[0 +: NOTE_W]), 64'd60);
        check("first_vel", 64'(voice_vel[0 +: NOTE_W]), 64'd100);
        check("first_retrig", 64'(voice_retrig), 64'h01);
        check("first_active", 64'(active_cnt), 64'd1);

        // Release then reuse: the least recently used free voice wins.
        do_reset();
        send(1'b1, 7'd60, 7'd80, 0);
        send(1'b1, 7'd62, 7'd80, 0);
        send(1'b1, 7'd64, 7'd80, 0);
        send(1'b0, 7'd62, 7'd0, 0);
        check("off_gate", 64'(voice_gate), 64'h05);
        check("off_note_kept", 64'(voice_note[1*NOTE_W +: NOTE_W]), 64'd62);
        send(1'b1, 7'd65, 7'd70, 0);
        check("lru_note", 64'(voice_note[3*NOTE_W +: NOTE_W]), 64'd65);
        check("lru_retrig", 64'(voice_retrig), 64'h08);
        check("lru_active", 64'(active_cnt), 64'd3);

        // Full pool: ninth note steals the oldest voice.
        do_reset();
        for (int n = 40; n <= 48; n++) send(1'b1, 7'(n), 7'd64, 0);
        check("steal_note", 64'(voice_note[0 +: NOTE_W]), 64'd48);
        check("steal_pulse", 64'(stolen), 64'd1);
        check("steal_retrig", 64'(voice_retrig), 64'h01);
        check("steal_active", 64'(active_cnt), 64'd8);

        // Same-note retrigger keeps the voice and takes the new velocity.
        do_reset();
        send(1'b1, 7'd60, 7'd50, 0);
        send(1'b1, 7'd60, 7'd90, 0);
        check("retrig_vel", 64'(voice_vel[0 +: NOTE_W]), 64'd90);
        check("retrig_gate", 64'(voice_gate), 64'h01);
        check("retrig_active", 64'(active_cnt), 64'd1);

        // Velocity 0 note-on releases; unmatched note-off does nothing.
        send(1'b1, 7'd60, 7'd0, 0);
        check("vel0_gate", 64'(voice_gate), 64'h00);
        check("vel0_note_kept", 64'(voice_note[0 +: NOTE_W]), 64'd60);
        check("vel0_retrig", 64'(voice_retrig), 64'h00);
        send(1'b0, 7'd99, 7'd0, 0);
        check("nomatch_gate", 64'(voice_gate), 64'h00);

        // ev_valid while busy is dropped.
        send(1'b1, 7'd70, 7'd20, 1);
        check("busy_note", 64'(voice_note[1*NOTE_W +: NOTE_W]), 64'd70);
        check("busy_gate", 64'(voice_gate), 64'h02);

        // rst during the scan discards the event.
        send(1'b1, 7'd72, 7'd20, 2);
        check("abort_gate", 64'(voice_gate), 64'h00);
        check("abort_ready", 64'(ev_ready), 64'd1);
        check("abort_note", 64'(voice_note[1*NOTE_W +: NOTE_W]), 64'd0);
        send(1'b1, 7'd61, 7'd30, 0);
        check("after_abort_gate", 64'(voice_gate), 64'h01);

`ifdef VOICE_ALLOC_SUSTAIN_EN
        do_reset();
        sustain = 1'b1;
        send(1'b1, 7'd60, 7'd100, 0);
        send(1'b0, 7'd60, 7'd0, 0);
        check("sus_hold_gate", 64'(voice_gate), 64'h01);
        send(1'b0, 7'd60, 7'd0, 0);
        send(1'b1, 7'd60, 7'd40, 0);
        check("sus_new_voice", 64'(voice_gate), 64'h03);
        step();
        sustain   = 1'b0;
        exp_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int i = 0; i < VOICES; i++)
            if (m_held[i]) begin
                m_gate[i] = 1'b0;
                m_held[i] = 1'b0;
            end
        exp_ready = 1'b1;
        check("sus_release_gate", 64'(voice_gate), 64'h02);
`endif

        step();
        step();
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
